// File: rtl/mul_shift_add.sv
// ---------------------------------------------------------------------------
// mul_shift_add
//
// Sequential unsigned shift-and-add multiply-accumulate. Rebuilds
// dividend = quotient * divisor + remainder, the inverse of the
// shift-subtract divider. One divisor bit is consumed per clock, so every
// operation takes exactly DIVISOR_WIDTH iteration cycles.
//
// Ports:
//   clk        - clock
//   reset      - asynchronous, active-high reset
//   valid_in   - operands valid; accepted when ready is high
//   ready      - high only while idle
//   quotient   - multiplicand, unsigned, DIVIDEND_WIDTH bits
//   divisor    - multiplier, unsigned, DIVISOR_WIDTH bits
//   remainder  - addend, unsigned, DIVISOR_WIDTH bits
//   dividend   - low DIVIDEND_WIDTH bits of quotient*divisor+remainder
//   valid_out  - one-cycle pulse; result outputs valid from this cycle on
//   overflow   - full result does not fit in DIVIDEND_WIDTH bits
//   rem_err    - remainder >= divisor (not a legal divider result)
// ---------------------------------------------------------------------------
module mul_shift_add #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready,
    input  logic [DIVIDEND_WIDTH-1:0] quotient,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    input  logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic [DIVIDEND_WIDTH-1:0] dividend,
    output logic                      valid_out,
    output logic                      overflow,
    output logic                      rem_err
);

    // The accumulator is wide enough that the largest q*d+r never wraps.
    localparam int ACC_W = DIVIDEND_WIDTH + DIVISOR_WIDTH;
    localparam int CNT_W = $clog2(DIVISOR_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q,     state_d;
    logic [ACC_W-1:0]          acc_q,       acc_d;
    logic [ACC_W-1:0]          mcand_q,     mcand_d;
    logic [DIVISOR_WIDTH-1:0]  mplier_q,    mplier_d;
    logic [CNT_W-1:0]          cnt_q,       cnt_d;
    logic                      rem_lat_q,   rem_lat_d;
    logic [DIVIDEND_WIDTH-1:0] dividend_q,  dividend_d;
    logic                      overflow_q,  overflow_d;
    logic                      rem_err_q,   rem_err_d;
    logic                      valid_out_q, valid_out_d;
    logic [ACC_W-1:0]          acc_sum_s;

    // Next-state and datapath logic for the iteration FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        rem_lat_d   = rem_lat_q;
        dividend_d  = dividend_q;
        overflow_d  = overflow_q;
        rem_err_d   = rem_err_q;
        valid_out_d = 1'b0;
        // Partial product added only when the current multiplier bit is set.
        acc_sum_s   = acc_q + (mplier_q[0] ? mcand_q : {ACC_W{1'b0}});

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    acc_d     = {{DIVIDEND_WIDTH{1'b0}}, remainder};
                    mcand_d   = {{DIVISOR_WIDTH{1'b0}}, quotient};
                    mplier_d  = divisor;
                    cnt_d     = CNT_W'(DIVISOR_WIDTH);
                    rem_lat_d = (remainder >= divisor);
                    state_d   = RUN;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                acc_d    = acc_sum_s;
                mcand_d  = {mcand_q[ACC_W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[DIVISOR_WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                // Last iteration: outputs load from the final sum so they
                // are valid in the same cycle as the valid_out pulse.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    dividend_d  = acc_sum_s[DIVIDEND_WIDTH-1:0];
                    overflow_d  = |acc_sum_s[ACC_W-1:DIVIDEND_WIDTH];
                    rem_err_d   = rem_lat_q;
                    valid_out_d = 1'b1;
                end else begin
                    state_d     = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            mcand_q     <= {ACC_W{1'b0}};
            mplier_q    <= {DIVISOR_WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rem_lat_q   <= 1'b0;
            dividend_q  <= {DIVIDEND_WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            rem_err_q   <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            rem_lat_q   <= rem_lat_d;
            dividend_q  <= dividend_d;
            overflow_q  <= overflow_d;
            rem_err_q   <= rem_err_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign dividend  = dividend_q;
    assign overflow  = overflow_q;
    assign rem_err   = rem_err_q;
    assign valid_out = valid_out_q;

endmodule

// File: doc/mul_shift_add.md
Name: mul_shift_add

Overview:
- Sequential unsigned shift-and-add multiply-accumulate. It is the inverse of the team's shift-subtract divider: it rebuilds dividend = quotient * divisor + remainder.
- Used in the FM radio datapath to re-scale divided values. Also used by the divider's self-check bench and by a run-time consistency monitor.
- Processes one multiplier (divisor) bit per cycle, giving fixed latency. Uses a valid/ready input handshake and a one-cycle valid_out pulse.

Parameters:
- DIVIDEND_WIDTH, 64, width of the quotient input and the dividend output.
- DIVISOR_WIDTH, 32, width of the divisor and remainder inputs; also the number of iteration cycles.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  operands valid; accepted when ready=1
- ready  output  1  high in IDLE only
- quotient  input  DIVIDEND_WIDTH  multiplicand, unsigned
- divisor  input  DIVISOR_WIDTH  multiplier, unsigned
- remainder  input  DIVISOR_WIDTH  addend, unsigned
- dividend  output  DIVIDEND_WIDTH  low DIVIDEND_WIDTH bits of quotient*divisor+remainder
- valid_out  output  1  one-cycle pulse; result outputs are valid from this cycle on
- overflow  output  1  full result does not fit in DIVIDEND_WIDTH bits
- rem_err  output  1  remainder >= divisor; the operand triple is not a legal divider result

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - On reset: state=IDLE, ready=1, valid_out=0, dividend=0, overflow=0, rem_err=0, all internal registers 0.
  - Reset mid-operation aborts the operation. No valid_out is produced for it.
- Internal registers:
  - acc, DIVIDEND_WIDTH+DIVISOR_WIDTH bits. Sized so that the maximum q*d+r cannot overflow it.
  - mcand, same width as acc.
  - mplier, DIVISOR_WIDTH bits.
  - cnt, $clog2(DIVISOR_WIDTH+1) bits.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On valid_in=1 at a clock edge:
    - acc <= zero-extended remainder.
    - mcand <= zero-extended quotient.
    - mplier <= divisor.
    - cnt <= DIVISOR_WIDTH.
    - rem_err register <= (remainder >= divisor).
    - Go to RUN.
  - The valid_in cycle is the accept cycle (cycle 0).
- RUN: one iteration per cycle, ready=0, valid_in ignored.
  - If mplier[0]=1: acc <= acc + mcand (full-width unsigned add, no truncation).
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - cnt <= cnt - 1.
  - When cnt==1 on this edge, go to DONE.
  - No early termination: exactly DIVISOR_WIDTH RUN cycles, even when divisor=0.
- DONE: one cycle.
  - Registered outputs update on entry:
    - dividend = acc[DIVIDEND_WIDTH-1:0].
    - overflow = |acc[top DIVISOR_WIDTH bits].
    - rem_err = latched value.
  - valid_out=1 for exactly this cycle. Next state is IDLE.
- Latency: valid_out is high in cycle DIVISOR_WIDTH+1 after the accept cycle (cycle 33 at defaults).
  - Throughput: one operation per DIVISOR_WIDTH+2 cycles.
  - The next accept can happen in the cycle after DONE.
- Output hold: dividend, overflow and rem_err keep their values until the next DONE or a reset. They do not change during IDLE or RUN.
- Boundary conditions:
  - divisor=0: result = remainder, overflow=0, rem_err=1.
  - quotient=0: result = remainder.
  - All-ones operands: acc reaches exactly (2^DIVISOR_WIDTH-1)*2^DIVIDEND_WIDTH with no wrap.
  - overflow set: dividend still carries the truncated low bits.
  - valid_in held high through a whole operation: a new operation starts in the first IDLE cycle after DONE.
- Operand capture: inputs are sampled only at the accept edge. Later changes to the operands do not affect the operation in flight.
- All arithmetic is unsigned. There are no combinational paths from inputs to outputs except none; ready is decoded from state.

Test Plan:
- Basic: quotient=5, divisor=7, remainder=3, valid_in for 1 cycle.
  - Expect dividend=38, overflow=0, rem_err=0.
  - valid_out exactly 33 cycles after accept, high 1 cycle; ready low cycles 1-33.
- Max legal divisor: quotient=1, divisor=0xFFFF_FFFF, remainder=0xFFFF_FFFE.
  - Expect dividend=0x0000_0001_FFFF_FFFD, overflow=0, rem_err=0.
- Overflow: quotient=0xFFFF_FFFF_FFFF_FFFF, divisor=2, remainder=0.
  - Expect dividend=0xFFFF_FFFF_FFFF_FFFE, overflow=1.
  - All-ones on all inputs: dividend=0, overflow=1, rem_err=1.
- Divide-by-zero inverse: quotient=0x1234, divisor=0, remainder=9.
  - Expect dividend=9, overflow=0, rem_err=1, same 33-cycle latency.
- Handshake:
  - Hold valid_in=1 continuously with new operands changing every cycle. Only the operands present at each IDLE accept edge are used.
  - Results arrive every 34 cycles.
  - Outputs stay stable between valid_out pulses.
- Reset mid-op: assert reset in RUN cycle 10.
  - Outputs are immediately 0, ready=1, and no valid_out follows.
  - A fresh operation after reset release (5*7+3) gives 38.
